cronometro_mm_ss: RTL

Stopwatch core driven by the 1 Hz square wave from the frequency divider. It synchronizes and edge-detects the slow wave inside the fast `clk` domain, so `clk` stays the only clock. It runs a start/pause/clear state machine and keeps minutes:seconds as BCD digits. The digits feed the VGA character/digit renderer downstream.

---
 rtl/cronometro_mm_ss.sv | 138 +++++++++++++
 1 files changed

// File: rtl/cronometro_mm_ss.sv
// Stopwatch core: synchronizes a slow tick wave and two buttons into the clk domain,
// runs an IDLE/RUN/PAUSE state machine and keeps mm:ss as BCD digits.
module cronometro_mm_ss #(
  parameter int MIN_MAX = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_in,
  input  logic       btn_start_stop,
  input  logic       btn_clear,
  output logic [3:0] min_tens,
  output logic [3:0] min_units,
  output logic [2:0] sec_tens,
  output logic [3:0] sec_units,
  output logic       running,
  output logic       wrap,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic [3:0] MAX_T = 4'(MIN_MAX / 10);
  localparam logic [3:0] MAX_U = 4'(MIN_MAX % 10);

  // Bit 0: tick, bit 1: start/stop, bit 2: clear.
  logic [2:0] sync1, sync2, hist;
  logic [1:0] arm_cnt;
  logic [2:0] ev;
  logic       ev_tick, ev_ss, ev_clr;

  state_t     state, state_n;
  logic [3:0] min_tens_n, min_units_n, sec_units_n;
  logic [2:0] sec_tens_n;
  logic       wrap_n, count_en, at_max;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= '0;
      sync2   <= '0;
      hist    <= '0;
      arm_cnt <= '0;
    end else begin
      sync1 <= {btn_clear, btn_start_stop, tick_in};
      sync2 <= sync1;
      hist  <= sync2;
      if (arm_cnt != 2'd3) arm_cnt <= arm_cnt + 2'd1;
    end
  end

  // Edges are only trusted once history holds a real sample, so a level already
  // high at reset release is not mistaken for a rising edge.
  assign ev      = (arm_cnt == 2'd3) ? (sync2 & ~hist) : 3'b000;
  assign ev_tick = ev[0];
  assign ev_ss   = ev[1];
  assign ev_clr  = ev[2];

  assign at_max = (min_tens == MAX_T) && (min_units == MAX_U) &&
                  (sec_tens == 3'd5) && (sec_units == 4'd9);
  assign count_en = ev_tick && (state == RUN) && !ev_clr;

  always_comb begin
    state_n = state;
    if (ev_clr) begin
      state_n = IDLE;
    end else if (ev_ss) begin
      case (state)
        IDLE:    state_n = RUN;
        RUN:     state_n = PAUSE;
        PAUSE:   state_n = RUN;
        default: state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    min_tens_n  = min_tens;
    min_units_n = min_units;
    sec_tens_n  = sec_tens;
    sec_units_n = sec_units;
    wrap_n      = 1'b0;
    if (ev_clr) begin
      min_tens_n  = '0;
      min_units_n = '0;
      sec_tens_n  = '0;
      sec_units_n = '0;
    end else if (count_en) begin
      if (at_max) begin
        min_tens_n  = '0;
        min_units_n = '0;
        sec_tens_n  = '0;
        sec_units_n = '0;
        wrap_n      = 1'b1;
      end else if (sec_units != 4'd9) begin
        sec_units_n = sec_units + 4'd1;
      end else begin
        sec_units_n = '0;
        if (sec_tens != 3'd5) begin
          sec_tens_n = sec_tens + 3'd1;
        end else begin
          sec_tens_n = '0;
          if (min_units != 4'd9) begin
            min_units_n = min_units + 4'd1;
          end else begin
            min_units_n = '0;
            min_tens_n  = min_tens + 4'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      min_tens  <= '0;
      min_units <= '0;
      sec_tens  <= '0;
      sec_units <= '0;
      running   <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      state     <= state_n;
      min_tens  <= min_tens_n;
      min_units <= min_units_n;
      sec_tens  <= sec_tens_n;
      sec_units <= sec_units_n;
      running   <= (state_n == RUN);
      wrap      <= wrap_n;
    end
  end

  assign state_dbg = state;

endmodule
